mips_multicycle_ctrl: RTL and testbench

- Finite-state controller that sequences a multicycle MIPS datapath with one shared instruction/data memory, one ALU, and IR/ALUOut/Data holding registers.
- Supports lw, sw, R-type (add, sub, and, or, slt, xor), beq, addi and j.
- Adds a memory-ready handshake, illegal-instruction reporting and a retired-instruction counter.
- Sits in the mips wrapper beside the datapath and replaces the single-cycle controller.

---
 rtl/mips_mc_pkg.sv | 56 +++++
 rtl/mc_aludec.sv | 25 ++
 rtl/mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes, ALU operation codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_XOR = 6'b100110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Loads and stores share the address-calculation path.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder: funct field to ALU operation, flagging unsupported functs.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    // Map funct to ALU code; unknown functs fall back to AND with the flag set.
    always_comb begin
        alucontrol    = ALU_AND;
        funct_illegal = 1'b0;
        case (funct)
            F_ADD:   alucontrol = ALU_ADD;
            F_SUB:   alucontrol = ALU_SUB;
            F_AND:   alucontrol = ALU_AND;
            F_OR:    alucontrol = ALU_OR;
            F_SLT:   alucontrol = ALU_SLT;
            F_XOR:   alucontrol = ALU_XOR;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake, reports illegal encodings and
// counts retired instructions. Outputs decode directly from the state register
// so an asynchronous reset drops every enable immediately.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit USE_MEM_READY = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] instret_reg;
    logic             mem_rdy;
    logic             pcwrite, branch, retire;
    logic [2:0]       rtype_alu;
    logic             funct_illegal;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    mc_aludec u_aludec (
        .funct         (funct),
        .alucontrol    (rtype_alu),
        .funct_illegal (funct_illegal)
    );

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_RESET;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    // Next-state logic and Moore decode of the datapath controls.
    always_comb begin
        state_next = state_reg;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        alucontrol = ALU_AND;
        pcsrc      = PC_ALU;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                irwrite    = mem_rdy;
                pcwrite    = mem_rdy;
                if (mem_rdy)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = SRCB_IMMSH;
                alucontrol = ALU_ADD;
                if (is_mem_op(op))         state_next = S_MEMADR;
                else if (op == OP_RTYPE)   state_next = S_EXECUTE;
                else if (op == OP_BEQ)     state_next = S_BRANCH;
                else if (op == OP_ADDI)    state_next = S_ADDIEX;
                else if (op == OP_J)       state_next = S_JUMP;
                else begin
                    illegal_op = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_rdy)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_rdy) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = rtype_alu;
                if (funct_illegal) begin
                    illegal_op = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PC_ALUOUT;
                branch     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = PC_JUMP;
                pcwrite    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_RESET;
        endcase
    end

    assign pcen    = pcwrite | (branch & zero);
    assign instret = instret_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each instruction is expanded into
// its expected per-cycle control pattern, queued, and checked by a monitor.
module tb_mips_multicycle_ctrl;
    import mips_mc_pkg::*;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        pcen, illegal_op;
    logic [31:0] instret;
    logic [3:0]  state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32), .USE_MEM_READY(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
        .illegal_op(illegal_op), .instret(instret), .state(state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0]  alusrcb;
        logic [2:0]  alucontrol;
        logic [1:0]  pcsrc;
        logic        pcen, illegal;
        logic [31:0] instret;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        mon_e, mon_a;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt;
    logic [5:0]  legal_f [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110};

    // Monitor: compare every cycle for which an expectation was queued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a.st = state;          mon_a.iord = iord;
                mon_a.memwrite = memwrite; mon_a.irwrite = irwrite;
                mon_a.regdst = regdst;     mon_a.memtoreg = memtoreg;
                mon_a.regwrite = regwrite; mon_a.alusrca = alusrca;
                mon_a.alusrcb = alusrcb;   mon_a.alucontrol = alucontrol;
                mon_a.pcsrc = pcsrc;       mon_a.pcen = pcen;
                mon_a.illegal = illegal_op; mon_a.instret = instret;
                checks++;
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, mon_a, mon_e);
                end
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.instret = model_cnt;
        return e;
    endfunction

    // {legal, alu code} for an R-type funct.
    function automatic logic [3:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            6'b100110: return 4'b1101;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic op_known(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    // Drive one cycle's inputs, queue the expected outputs, advance a clock.
    task automatic step(input obs_t e, input logic mr, input logic z,
                        input logic [5:0] o, input logic [5:0] f);
        mem_ready = mr; zero = z; op = o; funct = f;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input int fw);
        obs_t e;
        logic mr;
        for (int i = 0; i <= fw; i++) begin
            mr = (i == fw);
            e = blank(S_FETCH);
            e.alusrcb = 2'b01; e.alucontrol = 3'b010;
            e.irwrite = mr; e.pcen = mr;
            step(e, mr, 1'($urandom), 6'($urandom), 6'($urandom));
        end
        e = blank(S_DECODE);
        e.alusrcb = 2'b11; e.alucontrol = 3'b010;
        e.illegal = !op_known(o);
        step(e, 1'($urandom), 1'($urandom), o, f);
    endtask

    task automatic run_instr(input int kind, input logic [5:0] f, input int fw,
                             input int mw, input logic bz);
        logic [5:0] o;
        logic [3:0] ar;
        logic       z;
        logic       mr;
        obs_t       e;
        case (kind)
            K_LW:   o = 6'b100011;
            K_SW:   o = 6'b101011;
            K_R:    o = 6'b000000;
            K_BEQ:  o = 6'b000100;
            K_ADDI: o = 6'b001000;
            K_J:    o = 6'b000010;
            default: begin
                o = 6'($urandom);
                while (op_known(o)) o = 6'($urandom);
            end
        endcase
        $display("instr kind=%0d op=%b funct=%b fw=%0d mw=%0d zero=%0d retired=%0d",
                 kind, o, f, fw, mw, bz, model_cnt);
        fetch_decode(o, f, fw);
        if (kind == K_ILL) return;
        z = 1'($urandom);
        case (kind)
            K_LW, K_SW: begin
                e = blank(S_MEMADR);
                e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
                step(e, 1'($urandom), z, o, f);
                for (int i = 0; i <= mw; i++) begin
                    mr = (i == mw);
                    e = blank(kind == K_LW ? S_MEMRD : S_MEMWR);
                    e.iord = 1'b1;
                    e.memwrite = (kind == K_SW);
                    step(e, mr, 1'($urandom), o, f);
                end
                if (kind == K_LW) begin
                    e = blank(S_MEMWB);
                    e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    step(e, 1'($urandom), z, o, f);
                end
            end
            K_R: begin
                ar = alu_ref(f);
                e = blank(S_EXECUTE);
                e.alusrca = 1'b1; e.alucontrol = ar[2:0]; e.illegal = !ar[3];
                step(e, 1'($urandom), z, o, f);
                if (!ar[3]) return;
                e = blank(S_ALUWB);
                e.regdst = 1'b1; e.regwrite = 1'b1;
                step(e, 1'($urandom), z, o, f);
            end
            K_BEQ: begin
                e = blank(S_BRANCH);
                e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = bz;
                step(e, 1'($urandom), bz, o, f);
            end
            K_ADDI: begin
                e = blank(S_ADDIEX);
                e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
                step(e, 1'($urandom), z, o, f);
                e = blank(S_ADDIWB);
                e.regwrite = 1'b1;
                step(e, 1'($urandom), z, o, f);
            end
            default: begin
                e = blank(S_JUMP);
                e.pcsrc = 2'b10; e.pcen = 1'b1;
                step(e, 1'($urandom), z, o, f);
            end
        endcase
        model_cnt = model_cnt + 32'd1;
    endtask

    task automatic reset_cycles(input int n);
        model_cnt = '0;
        reset = 1'b0;
        for (int i = 0; i < n; i++)
            step(blank(S_RESET), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
        reset = 1'b1;
        step(blank(S_RESET), 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
    endtask

    initial begin
        obs_t e;
        int   kind;
        logic [5:0] f;
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
        model_cnt = '0;
        @(posedge clk); #1;
        reset_cycles(3);

        // Directed cases
        run_instr(K_ADDI, 6'b000000, 0, 0, 1'b0);
        run_instr(K_LW,   6'b000000, 2, 2, 1'b0);
        run_instr(K_BEQ,  6'b000000, 0, 0, 1'b1);
        run_instr(K_BEQ,  6'b000000, 0, 0, 1'b0);
        run_instr(K_R,    6'b100110, 0, 0, 1'b0);
        run_instr(K_R,    6'b111111, 0, 0, 1'b0);
        run_instr(K_ILL,  6'b000000, 0, 0, 1'b0);
        run_instr(K_J,    6'b000000, 1, 0, 1'b0);
        run_instr(K_SW,   6'b000000, 0, 1, 1'b0);

        // Randomized mix
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 6);
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
            run_instr(kind, f, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        // sw stalled in MEMWR, reset pulled low on its second waiting cycle
        $display("instr kind=%0d op=%b sw aborted by reset in MEMWR", K_SW, 6'b101011);
        fetch_decode(6'b101011, 6'b000000, 0);
        e = blank(S_MEMADR);
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
        step(e, 1'b0, 1'b0, 6'b101011, 6'b000000);
        e = blank(S_MEMWR);
        e.iord = 1'b1; e.memwrite = 1'b1;
        step(e, 1'b0, 1'b0, 6'b101011, 6'b000000);
        mem_ready = 1'b0;
        #1;
        check1("memwr_we_before_reset", 32'(memwrite), 32'd1);
        reset = 1'b0;
        #1;
        check1("memwr_we_async_drop", 32'(memwrite), 32'd0);
        check1("state_async_reset", 32'(state), 32'(S_RESET));
        check1("instret_async_reset", instret, 32'd0);
        model_cnt = '0;
        exp_q.push_back(blank(S_RESET));
        @(posedge clk); #1;
        reset_cycles(1);

        for (int n = 0; n < 20; n++) begin
            kind = $urandom_range(0, 6);
            run_instr(kind, legal_f[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        check1("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
